sync_param_fifo: RTL and testbench

//  Parametrised single-clock FIFO; next generation of the 8-bit byte FIFO on the USB<->AES datapath.

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/fifo_regfile.sv | 24 ++
 rtl/sync_param_fifo.sv | 110 +++++++++++
 tb/tb_sync_param_fifo.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? int'($clog2(depth)) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return int'($clog2(depth + 1));
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  localparam fifo_status_t STATUS_RESET = '{
    empty:        1'b1,
    full:         1'b0,
    almost_empty: 1'b1,
    almost_full:  1'b0,
    overflow:     1'b0,
    underflow:    1'b0
  };

endpackage

// File: rtl/fifo_regfile.sv
// FIFO storage: one clocked write port, one asynchronous read port, no reset.
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [addr_w(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [addr_w(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]          rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_param_fifo.sv
// Parametrised single-clock FIFO with occupancy, thresholds, sticky errors,
// synchronous flush and selectable registered / first-word-fall-through read.
module sync_param_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 1,
  parameter int unsigned FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     w_enable,
  input  logic [WIDTH-1:0]         w_data,
  input  logic                     r_enable,
  output logic [WIDTH-1:0]         r_data,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned ADDR_W = addr_w(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned CNT_W  = cnt_w(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0] count_q, count_nxt;
  fifo_status_t     status_q, status_nxt;
  logic             clr, rd_ok, wr_ok;
  logic [WIDTH-1:0] mem_rdata;

  // rst/flush win over any request, so nothing is accepted on those cycles.
  assign clr   = rst || flush;
  assign rd_ok = r_enable && !status_q.empty && !clr;
  assign wr_ok = w_enable && (!status_q.full || rd_ok) && !clr;

  always_comb begin
    wr_ptr_nxt = wr_ptr_q;
    rd_ptr_nxt = rd_ptr_q;
    count_nxt  = count_q;
    if (wr_ok) wr_ptr_nxt = wr_ptr_q + PTR_W'(1);
    if (rd_ok) rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
    if (wr_ok && !rd_ok)      count_nxt = count_q + CNT_W'(1);
    else if (rd_ok && !wr_ok) count_nxt = count_q - CNT_W'(1);
  end

  // Status is precomputed from next-state pointers/count so it can be registered.
  always_comb begin
    status_nxt              = status_q;
    status_nxt.empty        = (wr_ptr_nxt == rd_ptr_nxt);
    status_nxt.full         = (wr_ptr_nxt == {~rd_ptr_nxt[PTR_W-1], rd_ptr_nxt[ADDR_W-1:0]});
    status_nxt.almost_empty = (count_nxt <= CNT_W'(AE_LEVEL));
    status_nxt.almost_full  = (count_nxt >= CNT_W'(AF_LEVEL));
    status_nxt.overflow     = status_q.overflow  || (w_enable && !wr_ok);
    status_nxt.underflow    = status_q.underflow || (r_enable && status_q.empty);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      status_q <= STATUS_RESET;
    end else begin
      wr_ptr_q <= wr_ptr_nxt;
      rd_ptr_q <= rd_ptr_nxt;
      count_q  <= count_nxt;
      status_q <= status_nxt;
    end
  end

  fifo_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (w_data),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shown directly; forced to zero while empty so reset reads 0.
      assign r_data = status_q.empty ? '0 : mem_rdata;
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (rst)        r_data <= '0;
        else if (rd_ok) r_data <= mem_rdata;
      end
    end
  endgenerate

  assign empty        = status_q.empty;
  assign full         = status_q.full;
  assign almost_empty = status_q.almost_empty;
  assign almost_full  = status_q.almost_full;
  assign overflow     = status_q.overflow;
  assign underflow    = status_q.underflow;
  assign count        = count_q;

endmodule

// File: tb/tb_sync_param_fifo.sv
// Bench for sync_param_fifo: registered and FWFT instances driven in lockstep
// against a queue-based reference model plus hand-computed expectations.
module tb_sync_param_fifo;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1, flush = 1'b0, w_enable = 1'b0, r_enable = 1'b0;
  logic [7:0] w_data = 8'h00;

  logic [7:0] r_data0, r_data1;
  logic [3:0] count0, count1;
  logic       empty0, full0, ae0, af0, ovf0, udf0;
  logic       empty1, full1, ae1, af1, ovf1, udf1;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  sync_param_fifo #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .w_enable(w_enable), .w_data(w_data),
    .r_enable(r_enable), .r_data(r_data0), .empty(empty0), .full(full0),
    .almost_empty(ae0), .almost_full(af0), .count(count0),
    .overflow(ovf0), .underflow(udf0));

  sync_param_fifo #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .w_enable(w_enable), .w_data(w_data),
    .r_enable(r_enable), .r_data(r_data1), .empty(empty1), .full(full1),
    .almost_empty(ae1), .almost_full(af1), .count(count1),
    .overflow(ovf1), .underflow(udf1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words and the last word popped.
  logic [7:0] q[$];
  logic [7:0] m_rd;
  bit         m_ovf, m_udf, m_rd_ok, m_wr_ok;

  always @(posedge clk) begin
    if (rst) begin
      q.delete(); m_ovf = 0; m_udf = 0; m_rd = 8'h00;
    end else if (flush) begin
      q.delete(); m_ovf = 0; m_udf = 0;
    end else begin
      m_rd_ok = r_enable && (q.size() != 0);
      m_wr_ok = w_enable && ((q.size() < DEPTH) || m_rd_ok);
      if (r_enable && q.size() == 0) m_udf = 1;
      if (w_enable && !m_wr_ok)      m_ovf = 1;
      if (m_rd_ok) m_rd = q.pop_front();
      if (m_wr_ok) q.push_back(w_data);
    end
  end

  task automatic cmp_status(input string tag, input logic [3:0] c, input logic e, f, ae, af, ov, un);
    int n;
    n = q.size();
    chk({tag, "_count"}, 32'(c), 32'(n));
    chk({tag, "_empty"}, 32'(e), 32'(n == 0));
    chk({tag, "_full"},  32'(f), 32'(n == DEPTH));
    chk({tag, "_aempty"}, 32'(ae), 32'(n <= 1));
    chk({tag, "_afull"}, 32'(af), 32'(n >= 6));
    chk({tag, "_ovf"},   32'(ov), 32'(m_ovf));
    chk({tag, "_udf"},   32'(un), 32'(m_udf));
  endtask

  // Every-cycle comparison against the model, once the first reset has settled.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (chk_en) begin
        cmp_status("reg", count0, empty0, full0, ae0, af0, ovf0, udf0);
        cmp_status("fwft", count1, empty1, full1, ae1, af1, ovf1, udf1);
        chk("reg_rdata", 32'(r_data0), 32'(m_rd));
        if (q.size() != 0) chk("fwft_rdata", 32'(r_data1), 32'(q[0]));
      end
    end
  end

  task automatic cyc(input logic rs, input logic fl, input logic we, input logic [7:0] wd, input logic re);
    @(negedge clk);
    rst = rs; flush = fl; w_enable = we; w_data = wd; r_enable = re;
    @(posedge clk); #3;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  logic [7:0] t2 [4] = '{8'h0F, 8'h00, 8'hFF, 8'h00};
  logic [7:0] d;

  initial begin
    // 1. reset
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk_en = 1'b1;
    idle();
    chk("t1_count", 32'(count0), 32'd0);
    chk("t1_empty", 32'({empty0, full0, ae0, af0, ovf0, udf0}), 32'b101000);
    chk("t1_rdata0", 32'(r_data0), 32'h00);
    chk("t1_rdata1", 32'(r_data1), 32'h00);

    // 2. ordered write then read
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, t2[i], 1'b0);
    chk("t2_count", 32'(count1), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_fwft_head", 32'(r_data1), 32'(t2[i]));
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("t2_reg_data", 32'(r_data0), 32'(t2[i]));
    end
    chk("t2_empty", 32'(empty0), 32'd1);
    idle();

    // 3. fill, thresholds, overflow, drain
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'(i), 1'b0);
      if (i == 5) chk("t3_af_at5", 32'(af0), 32'd0);
      if (i == 6) chk("t3_af_at6", 32'(af0), 32'd1);
      if (i == 7) chk("t3_full_at7", 32'(full0), 32'd0);
    end
    chk("t3_full", 32'(full0), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0);
    chk("t3_ovf", 32'({ovf0, ovf1}), 32'b11);
    chk("t3_count", 32'(count0), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("t3_drain", 32'(r_data0), 32'(i));
    end
    chk("t3_empty", 32'(empty1), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("t3_flush_ovf", 32'(ovf0), 32'd0);

    // 4. preload 4, then 1000 cycles of simultaneous r/w (125 pointer wraps)
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b1, (k % 2 == 0) ? 8'h55 : 8'hAA, 1'b0);
    for (int k = 4; k < 1004; k++) begin
      d = (k % 2 == 0) ? 8'h55 : 8'hAA;
      cyc(1'b0, 1'b0, 1'b1, d, 1'b1);
      // four entries of delay on a period-2 pattern returns the same value
      if (k % 97 == 0) chk("t4_stream", 32'(r_data0), 32'(d));
    end
    chk("t4_count", 32'(count0), 32'd4);
    chk("t4_noflags", 32'({ovf0, udf0, ovf1, udf1}), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    idle();

    // 5. underflow, flush, simultaneous r/w on empty
    d = r_data0;
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("t5_udf", 32'({udf0, udf1}), 32'b11);
    chk("t5_count", 32'(count0), 32'd0);
    chk("t5_hold", 32'(r_data0), 32'(d));
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("t5_flush_udf", 32'(udf0), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'h77, 1'b1);
    chk("t5_rw_count", 32'(count0), 32'd1);
    chk("t5_rw_udf", 32'(udf0), 32'd1);
    chk("t5_rw_hold", 32'(r_data0), 32'(d));
    chk("t5_fwft_vis", 32'(r_data1), 32'h77);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // 6. reset wins over concurrent r/w, then no stale data
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
    chk("t6_count5", 32'(count0), 32'd5);
    cyc(1'b1, 1'b0, 1'b1, 8'hEE, 1'b1);
    chk("t6_rst_count", 32'(count0), 32'd0);
    chk("t6_rst_flags", 32'({empty0, full0, ovf0, udf0, empty1, ovf1, udf1}), 32'b1000100);
    chk("t6_rst_rdata", 32'(r_data0), 32'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);
    chk("t6_fwft", 32'(r_data1), 32'h3C);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("t6_reg", 32'(r_data0), 32'h3C);
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
